// File: rtl/itch_pkg.sv
// Shared types and helpers for the UDP/ITCH front-end: sequencer states, header constants, keep helpers.
// No logic of its own; no latency; no backpressure.
package itch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_FLUSH,
        ST_DROP
    } seq_state_t;

    localparam logic [15:0] ETH_IPV4_LE  = 16'h0008;
    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
    localparam logic [2:0]  PAYLOAD_BEAT = 3'd5;
    localparam logic [3:0]  PAYLOAD_OFS  = 4'd2;

    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] count_mask(input logic [3:0] n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (4'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/payload_realign_stage.sv
// Shifts the UDP payload (frame byte 42 onward) by two bytes onto 8-byte word boundaries.
// Latency: one cycle from load/shift/flush to output. No backpressure: one word per control pulse.
module payload_realign_stage
    import itch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_shift,
    input  logic        i_flush,
    input  logic        i_eop,
    input  logic [3:0]  i_k,
    input  logic [63:0] i_data,
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic [7:0]  o_keep,
    output logic        o_eop
);

    logic [47:0] r_held;
    logic [3:0]  r_k;
    logic        r_valid;
    logic [63:0] r_data;
    logic [7:0]  r_keep;
    logic        r_eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held  <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_eop   <= 1'b0;
        end else begin
            r_valid <= i_shift | i_flush;
            r_data  <= '0;
            r_keep  <= '0;
            r_eop   <= 1'b0;
            if (i_flush) begin
                // r_k is the byte count of the frame's final beat
                r_data <= {16'h0000, r_held};
                r_keep <= count_mask(r_k - PAYLOAD_OFS);
                r_eop  <= 1'b1;
            end else if (i_shift) begin
                r_data <= {i_data[15:0], r_held};
                if (i_eop && (i_k <= PAYLOAD_OFS)) begin
                    r_keep <= count_mask(4'd8 - PAYLOAD_OFS + i_k);
                    r_eop  <= 1'b1;
                end else begin
                    r_keep <= 8'hFF;
                end
            end
            if (i_load | i_shift) begin
                r_held <= i_data[63:16];
                r_k    <= i_k;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_eop   = r_eop;

endmodule

// File: rtl/udp_payload_sequencer.sv
// Frame controller: indexes header beats for the decoders, filters non-IPv4/UDP frames, realigns UDP payload.
// Latency: dec_* and out_* one cycle after the accepted beat (flush word one cycle after the FLUSH state).
// No backpressure: every valid beat is consumed; idle gaps hold state.
module udp_payload_sequencer
    import itch_pkg::*;
#(
    parameter int MIN_HDR_BEATS = 6,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [7:0]       in_keep,
    input  logic [63:0]      in_data,
    output logic             dec_valid,
    output logic [2:0]       dec_idx,
    output logic [63:0]      dec_data,
    output logic             out_valid,
    output logic [63:0]      out_data,
    output logic [7:0]       out_keep,
    output logic             out_eop,
    output logic             out_abort,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_drop
);

    seq_state_t       r_state, w_state_nxt;
    logic [2:0]       r_bidx, w_bidx_nxt, w_bidx_inc, w_dec_idx;
    logic             r_dec_vld, w_dec_vld;
    logic [2:0]       r_dec_idx;
    logic [63:0]      r_dec_data;
    logic             r_abort, w_abort;
    logic [CNT_W-1:0] r_frames_ok, r_frames_drop;
    logic             w_ok_inc;
    logic [1:0]       w_drop_inc;
    logic             w_load, w_shift, w_flush;
    logic [3:0]       w_k;
    logic             w_hdr_bad;

    assign w_k        = keep_count(in_keep);
    assign w_bidx_inc = (r_bidx == 3'd6) ? 3'd6 : r_bidx + 3'd1;
    assign w_hdr_bad  = ((r_bidx == 3'd1) && (in_data[47:32] != ETH_IPV4_LE)) ||
                        ((r_bidx == 3'd2) && (in_data[63:56] != IP_PROTO_UDP));

    always_comb begin
        w_state_nxt = r_state;
        w_bidx_nxt  = r_bidx;
        w_dec_vld   = 1'b0;
        w_dec_idx   = r_bidx;
        w_abort     = 1'b0;
        w_ok_inc    = 1'b0;
        w_drop_inc  = 2'd0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_flush     = (r_state == ST_FLUSH);

        // FLUSH completes on its own cycle whether or not a beat arrives
        if (r_state == ST_FLUSH) begin
            w_ok_inc    = 1'b1;
            w_state_nxt = ST_IDLE;
        end

        if (in_valid) begin
            if (in_sop) begin
                w_dec_vld  = 1'b1;
                w_dec_idx  = 3'd0;
                w_bidx_nxt = 3'd1;
                if (r_state == ST_PAYLOAD) begin
                    w_abort    = 1'b1;
                    w_drop_inc = w_drop_inc + 2'd1;
                end
                if (r_state == ST_HDR) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                end
                if (in_eop) begin
                    w_drop_inc  = w_drop_inc + 2'd1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HDR;
                end
            end else begin
                case (r_state)
                    ST_HDR: begin
                        w_dec_vld  = 1'b1;
                        w_bidx_nxt = w_bidx_inc;
                        if (r_bidx == 3'(MIN_HDR_BEATS - 1)) begin
                            w_load = 1'b1;
                            if (!in_eop) begin
                                w_state_nxt = ST_PAYLOAD;
                            end else if (w_k <= PAYLOAD_OFS) begin
                                w_ok_inc    = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_state_nxt = ST_FLUSH;
                            end
                        end else if (w_hdr_bad || in_eop) begin
                            w_drop_inc  = 2'd1;
                            w_state_nxt = in_eop ? ST_IDLE : ST_DROP;
                        end
                    end
                    ST_DROP: begin
                        w_dec_vld  = (r_bidx <= PAYLOAD_BEAT);
                        w_bidx_nxt = w_bidx_inc;
                        if (in_eop) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    ST_PAYLOAD: begin
                        w_shift = 1'b1;
                        if (in_eop) begin
                            if (w_k <= PAYLOAD_OFS) begin
                                w_ok_inc    = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_state_nxt = ST_FLUSH;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_bidx        <= '0;
            r_dec_vld     <= 1'b0;
            r_dec_idx     <= '0;
            r_dec_data    <= '0;
            r_abort       <= 1'b0;
            r_frames_ok   <= '0;
            r_frames_drop <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_bidx        <= w_bidx_nxt;
            r_dec_vld     <= w_dec_vld;
            r_abort       <= w_abort;
            r_frames_ok   <= r_frames_ok + CNT_W'(w_ok_inc);
            r_frames_drop <= r_frames_drop + CNT_W'(w_drop_inc);
            if (w_dec_vld) begin
                r_dec_idx  <= w_dec_idx;
                r_dec_data <= in_data;
            end
        end
    end

    payload_realign_stage u_realign (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_flush (w_flush),
        .i_eop   (in_eop),
        .i_k     (w_k),
        .i_data  (in_data),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_keep  (out_keep),
        .o_eop   (out_eop)
    );

    assign dec_valid   = r_dec_vld;
    assign dec_idx     = r_dec_idx;
    assign dec_data    = r_dec_data;
    assign out_abort   = r_abort;
    assign frames_ok   = r_frames_ok;
    assign frames_drop = r_frames_drop;

endmodule

// File: tb/tb_udp_payload_sequencer.sv
// Directed table-driven bench for udp_payload_sequencer: frames, filters, runts, aborts, flush overlap, gaps, reset.
module tb_udp_payload_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sop, in_eop;
    logic [7:0]  in_keep;
    logic [63:0] in_data;
    logic        dec_valid;
    logic [2:0]  dec_idx;
    logic [63:0] dec_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_eop, out_abort;
    logic [15:0] frames_ok, frames_drop;

    always #5 clk = ~clk;

    udp_payload_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_keep    (in_keep),
        .in_data    (in_data),
        .dec_valid  (dec_valid),
        .dec_idx    (dec_idx),
        .dec_data   (dec_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_eop    (out_eop),
        .out_abort  (out_abort),
        .frames_ok  (frames_ok),
        .frames_drop(frames_drop)
    );

    typedef struct {
        logic        v, s, e;
        logic [7:0]  k;
        logic [63:0] d;
        logic        xov, xoe, xa, xdv;
        logic [7:0]  xkeep;
        logic [63:0] xod;
        logic [2:0]  xdi;
        logic [15:0] xok, xdrop;
    } vec_t;

    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_ok = 0;
    int          exp_drop = 0;
    logic        pend = 1'b0;
    logic [7:0]  pend_keep;
    logic [63:0] pend_data;

    function automatic logic [7:0] fbyte(input int f, input int i);
        if (i == 12) return 8'h08;
        if (i == 13) return 8'h00;
        if (i == 23) return 8'h11;
        return 8'(i + 16 * f);
    endfunction

    function automatic logic [63:0] fbeat(input int f, input int b);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = fbyte(f, 8 * b + j);
        return d;
    endfunction

    // Payload byte n of frame f is frame byte 42+n
    function automatic logic [63:0] pword(input int f, input int w);
        logic [63:0] p;
        for (int j = 0; j < 8; j++) p[8*j +: 8] = 8'(42 + 8 * w + j + 16 * f);
        return p;
    endfunction

    function automatic logic [7:0] nmask(input int n);
        logic [7:0] m;
        m = 8'h00;
        for (int j = 0; j < n; j++) m[j] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bytemask(input logic [7:0] k);
        logic [63:0] m;
        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{k[j]}};
        return m;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic push(input logic v, s, e, input logic [7:0] k, input logic [63:0] d,
                        input logic xov, input logic [7:0] xkeep, input logic xoe, input logic [63:0] xod,
                        input logic xa, xdv, input logic [2:0] xdi);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.k = k; r.d = d;
        r.xov = xov; r.xkeep = xkeep; r.xoe = xoe; r.xod = xod;
        r.xa = xa; r.xdv = xdv; r.xdi = xdi;
        r.xok = 16'(exp_ok); r.xdrop = 16'(exp_drop);
        tbl.push_back(r);
    endtask

    // prev: 0 idle before sop, 1 previous frame mid-payload (abort), 2 previous frame mid-header
    task automatic add_frame(input int f, input int nb, input logic [7:0] lk, input logic has_eop,
                             input logic bad, input logic chain, input int prev, input int gap);
        logic [63:0] d, xod;
        logic [7:0]  k, xkeep;
        logic        e, xov, xoe, xa;
        int          kc;
        for (int b = 0; b < nb; b++) begin
            if (b > 0)
                for (int g = 0; g < gap; g++) push(0, 0, 0, 8'h00, 64'h0, 0, 8'h00, 0, 64'h0, 0, 0, 3'd0);
            d = fbeat(f, b);
            if (bad && b == 1) d[47:32] = 16'hDD86;
            e = has_eop && (b == nb - 1);
            k = e ? lk : 8'hFF;
            kc = $countones(k);
            xov = 0; xkeep = 8'h00; xoe = 0; xod = 64'h0; xa = 0;
            if (b == 0) begin
                if (pend) begin
                    xov = 1; xkeep = pend_keep; xoe = 1; xod = pend_data;
                    exp_ok++; pend = 0;
                end
                if (prev == 1) begin xa = 1; exp_drop++; end
                if (prev == 2) exp_drop++;
            end
            if (!bad && b >= 6) begin
                xov = 1; xod = pword(f, b - 6);
                xoe = e && (kc <= 2);
                xkeep = xoe ? nmask(6 + kc) : 8'hFF;
            end
            if (bad && b == 1) exp_drop++;
            if (e && !bad && b < 5) exp_drop++;
            if (e && !bad && b >= 5 && kc <= 2) exp_ok++;
            push(1, b == 0, e, k, d, xov, xkeep, xoe, xod, xa, b <= 5, 3'(b));
            if (e && !bad && b >= 5 && kc > 2) begin
                pend = 1; pend_keep = nmask(kc - 2); pend_data = pword(f, b - 5);
            end
        end
        if (pend && !chain) begin
            exp_ok++;
            push(0, 0, 0, 8'h00, 64'h0, 1, pend_keep, 1, pend_data, 0, 0, 3'd0);
            pend = 0;
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            in_valid = tbl[i].v; in_sop = tbl[i].s; in_eop = tbl[i].e;
            in_keep = tbl[i].k; in_data = tbl[i].d;
            @(posedge clk);
            #1;
            chk("out_valid", i, 64'(out_valid), 64'(tbl[i].xov));
            if (tbl[i].xov) begin
                chk("out_keep", i, 64'(out_keep), 64'(tbl[i].xkeep));
                chk("out_data", i, out_data & bytemask(tbl[i].xkeep), tbl[i].xod & bytemask(tbl[i].xkeep));
            end
            chk("out_eop", i, 64'(out_eop), 64'(tbl[i].xoe));
            chk("out_abort", i, 64'(out_abort), 64'(tbl[i].xa));
            chk("dec_valid", i, 64'(dec_valid), 64'(tbl[i].xdv));
            if (tbl[i].xdv) begin
                chk("dec_idx", i, 64'(dec_idx), 64'(tbl[i].xdi));
                chk("dec_data", i, dec_data, tbl[i].d);
            end
            chk("frames_ok", i, 64'(frames_ok), 64'(tbl[i].xok));
            chk("frames_drop", i, 64'(frames_drop), 64'(tbl[i].xdrop));
        end
        tbl.delete();
        @(negedge clk);
        in_valid = 0; in_sop = 0; in_eop = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 0, 64'(out_valid), 64'h0);
        chk({tag, "_out_data"}, 0, out_data, 64'h0);
        chk({tag, "_out_keep"}, 0, 64'(out_keep), 64'h0);
        chk({tag, "_out_eop"}, 0, 64'(out_eop), 64'h0);
        chk({tag, "_out_abort"}, 0, 64'(out_abort), 64'h0);
        chk({tag, "_dec_valid"}, 0, 64'(dec_valid), 64'h0);
        chk({tag, "_dec_idx"}, 0, 64'(dec_idx), 64'h0);
        chk({tag, "_dec_data"}, 0, dec_data, 64'h0);
        chk({tag, "_frames_ok"}, 0, 64'(frames_ok), 64'h0);
        chk({tag, "_frames_drop"}, 0, 64'(frames_drop), 64'h0);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_sop = 0; in_eop = 0; in_keep = 8'h00; in_data = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 0;

        add_frame(0, 10, 8'hFF, 1, 0, 0, 0, 0);   // 80-byte frame, 38 payload bytes
        add_frame(1, 10, 8'hFF, 1, 1, 0, 0, 0);   // IPv6 ethertype: filtered
        add_frame(2, 7, 8'hFF, 1, 0, 0, 0, 0);
        add_frame(3, 4, 8'hFF, 1, 0, 0, 0, 0);    // runt, eop on beat 3
        add_frame(4, 8, 8'h03, 1, 0, 0, 0, 0);    // k=2 on last beat: no flush
        add_frame(5, 8, 8'h01, 1, 0, 0, 0, 0);
        add_frame(6, 7, 8'hFF, 0, 0, 0, 0, 0);    // truncated mid-payload
        add_frame(7, 10, 8'hFF, 1, 0, 0, 1, 0);   // sop aborts frame 6
        add_frame(8, 6, 8'h3F, 1, 0, 1, 0, 0);    // ends on beat 5 with k=6, flush overlaps next sop
        add_frame(9, 6, 8'h03, 1, 0, 0, 0, 0);    // ends on beat 5 with k=2: no payload
        add_frame(10, 10, 8'hFF, 1, 0, 0, 0, 3);  // 3-cycle idle gaps
        add_frame(11, 3, 8'hFF, 0, 0, 0, 0, 0);   // truncated mid-header
        add_frame(12, 7, 8'hFF, 1, 0, 0, 2, 0);
        run_table();

        // Reset in the middle of a payload frame
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            in_valid = 1; in_sop = (b == 0); in_eop = 0; in_keep = 8'hFF; in_data = fbeat(13, b);
            @(posedge clk);
            #1;
        end
        chk("pre_rst_out_valid", 0, 64'(out_valid), 64'h1);
        chk("pre_rst_out_data", 0, out_data, pword(13, 1));
        @(negedge clk);
        rst = 1; in_valid = 0; in_sop = 0;
        @(posedge clk);
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 0;
        exp_ok = 0; exp_drop = 0; pend = 0;
        add_frame(14, 10, 8'hFF, 1, 0, 0, 0, 0);
        run_table();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
